led_frame_streamer: RTL and testbench
=====================================

# led_frame_streamer

Double-buffered pixel store and frame sequencer that feeds the unipolar return-to-zero line encoder. A host writes 24-bit RGB pixels into a back buffer and requests frames. The block reorders each pixel to GRB and bit-reverses it so the encoder's LSB-first shifting emits MSB-first GRB. It then streams one word per pixel over a valid/ready handshake and releases `enable` at frame end so the encoder performs its latch/reset period.

## Interface
- `NUM_LEDS`, default 8: pixels per frame, must be ≥ 1.
- `ADDR_WIDTH`, default `$clog2(NUM_LEDS)`, minimum 1: pixel address width.
- `clock`  input  1  system clock; all logic on its rising edge.
- `reset_n`  input  1  reset, asynchronous and active-low.
- `wr_en`  input  1  write strobe into the back buffer.
- `wr_addr`  input  ADDR_WIDTH  pixel index, 0 … NUM_LEDS-1.
- `wr_data`  input  24  pixel as {R[7:0], G[7:0], B[7:0]}.
- `swap`  input  1  single-cycle pulse requesting a front/back exchange at the next frame boundary.
- `start`  input  1  single-cycle pulse requesting one frame transmission.
- `busy`  output  1  high from frame launch until `frame_done`.
- `frame_done`  output  1  single-cycle pulse when the last pixel word is accepted.
- `data`  output  24  word to the encoder.
- `enable`  output  1  word valid.
- `ready`  input  1  encoder accepts the word.

## Operation
- Storage: two NUM_LEDS×24 arrays with synchronous read and 1-cycle latency. `front_sel` selects the array being read; writes always target the other (back) array.
- Writes:
  - accepted every cycle, including while busy;
  - `wr_addr` ≥ NUM_LEDS is ignored;
  - a write never affects the array being transmitted.
- Word format: `data[i]` = G[7-i] for i = 0..7, R[7-(i-8)] for i = 8..15, B[7-(i-16)] for i = 16..23. The encoder therefore emits G7 first and B0 last.
- Pending flags:
  - `start_pend` is set by `start` and cleared at launch;
  - `swap_pend` is set by `swap` and cleared when applied;
  - additional pulses while a flag is already set are absorbed, with no queueing beyond one.
- Handshake: a word transfers on a rising edge where `enable` && `ready`. `data` is held stable while `enable` is high and `ready` is low.
- State machine:
  - IDLE: `enable`=0, `busy`=0. If `start_pend`: toggle `front_sel` when `swap_pend` (clear it), clear `start_pend`, issue read of pixel 0, go to FETCH.
  - FETCH: register formatted pixel into `data`, set `enable`=1, issue prefetch of pixel 1 (if NUM_LEDS > 1), go to SEND.
  - SEND: on transfer, if the index is not the last, load the prefetched word into `data` the same edge with `enable` staying high, and issue the next prefetch. On transfer of pixel NUM_LEDS-1: `enable`←0, pulse `frame_done`, go to IDLE.
- A `swap` arriving mid-frame is applied only at the next launch. A `start` arriving mid-frame launches immediately after the current frame's return to IDLE.

## Timing
- Reset values: `data`=0, `enable`=0, `busy`=0, `frame_done`=0, `front_sel`=0, `start_pend`=0, `swap_pend`=0, pixel index 0. Array contents are not reset.
- `reset_n` asserted mid-frame: all outputs take their reset values immediately. Partially sent frames are abandoned and are not resumed.
- `start` sampled at edge t in IDLE:
  - FETCH at t+1;
  - `enable`=1 and `busy`=1 visible after edge t+2;
  - `busy` rises together with the launch (after edge t+1).
- Back-to-back: with `ready` held high, one word transfers per cycle with no bubbles; the prefetch register always covers the 1-cycle read latency.
- Frame end: `frame_done` high for the cycle after the last transfer edge. `busy` falls on the same edge. The earliest relaunch is 1 cycle later, giving `enable` at least 2 low cycles between frames.
- Simultaneous `start` and `frame_done` cycle: the start is captured in `start_pend` and not lost.
- Simultaneous `wr_en` and `swap`: the write lands in the current back array. After the swap is applied, that array becomes front.

## Test plan
- Reset, then write pixel 0 = 0xFF0000 (red), NUM_LEDS=1, `swap`, `start`, `ready`=1 → one transfer with `data`=0x00FF00 (bit-reversed GRB), `frame_done` one cycle later, `enable` low after.
- NUM_LEDS=8 with ramp pixels, `ready` held high → 8 consecutive transfer cycles with no gaps and correct word order, `busy` high for exactly 9 cycles.
- `ready` toggled pseudo-randomly → every word is held stable until accepted and no word is duplicated or dropped.
- During a frame, write new data and pulse `swap` and `start` → the current frame sends old data and the following frame sends new data with no intervening host action.
- `start` pulsed twice mid-frame → exactly one extra frame is sent.
- Deassert `reset_n` after 3 of 8 transfers → `enable`, `busy` drop asynchronously. After release, IDLE resumes and a new `start` sends from pixel 0 of buffer 0.

Source files
------------

// File: rtl/led_frame_streamer.sv
// Double-buffered GRB pixel store and frame sequencer for the return-to-zero LED encoder.
// Streams one bit-reversed GRB word per pixel over valid/ready and drops enable at frame end.
module led_frame_streamer #(
    parameter int NUM_LEDS   = 8,
    parameter int ADDR_WIDTH = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [23:0]           wr_data,
    input  logic                  swap,
    input  logic                  start,
    output logic                  busy,
    output logic                  frame_done,
    output logic [23:0]           data,
    output logic                  enable,
    input  logic                  ready
);

    typedef enum logic [1:0] {IDLE, FETCH, SEND} state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_LEDS - 1);

    state_t                state, state_next;
    logic                  front_sel;
    logic                  start_pend, swap_pend;
    logic [ADDR_WIDTH-1:0] idx;
    logic [23:0]           rd_word;
    logic [23:0]           mem [0:1][0:NUM_LEDS-1];

    logic                  launch, load_first, advance, finish;
    logic                  rd_en, rd_bank;
    logic [ADDR_WIDTH-1:0] rd_addr;

    // The encoder shifts LSB first, so each colour byte is reversed to put G7 on the wire first.
    function automatic logic [23:0] to_wire(input logic [23:0] px);
        logic [23:0] w;
        w = '0;
        for (int i = 0; i < 8; i++) begin
            w[i]      = px[15-i];
            w[8 + i]  = px[23-i];
            w[16 + i] = px[7-i];
        end
        return w;
    endfunction

    // NOTE: the pixel arrays and read register carry no reset; only control state needs a known value.
    always_ff @(posedge clock) begin
        if (wr_en && (int'(wr_addr) < NUM_LEDS))
            mem[~front_sel][wr_addr] <= wr_data;
        if (rd_en)
            rd_word <= mem[rd_bank][rd_addr];
    end

    // NOTE: every output of this block gets a default first so no path leaves a latch behind.
    always_comb begin
        state_next = state;
        launch     = 1'b0;
        load_first = 1'b0;
        advance    = 1'b0;
        finish     = 1'b0;
        rd_en      = 1'b0;
        rd_bank    = front_sel;
        rd_addr    = '0;
        case (state)
            IDLE: begin
                if (start_pend) begin
                    launch     = 1'b1;
                    rd_en      = 1'b1;
                    rd_bank    = front_sel ^ swap_pend;
                    state_next = FETCH;
                end
            end
            FETCH: begin
                load_first = 1'b1;
                state_next = SEND;
                if (NUM_LEDS > 1) begin
                    rd_en   = 1'b1;
                    rd_addr = ADDR_WIDTH'(1);
                end
            end
            SEND: begin
                if (enable && ready) begin
                    if (idx == LAST_IDX) begin
                        finish     = 1'b1;
                        state_next = IDLE;
                    end else begin
                        advance = 1'b1;
                        // Prefetch two ahead: rd_word already holds pixel idx+1.
                        if (int'(idx) + 2 < NUM_LEDS) begin
                            rd_en   = 1'b1;
                            rd_addr = idx + ADDR_WIDTH'(2);
                        end
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            front_sel  <= 1'b0;
            start_pend <= 1'b0;
            swap_pend  <= 1'b0;
            idx        <= '0;
            data       <= '0;
            enable     <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_next;
            frame_done <= finish;

            if (launch)
                start_pend <= 1'b0;
            else
                start_pend <= start_pend | start;

            if (launch && swap_pend) begin
                swap_pend <= 1'b0;
                front_sel <= ~front_sel;
            end else begin
                swap_pend <= swap_pend | swap;
            end

            if (launch) begin
                busy <= 1'b1;
                idx  <= '0;
            end
            if (load_first) begin
                data   <= to_wire(rd_word);
                enable <= 1'b1;
            end
            if (advance) begin
                data <= to_wire(rd_word);
                idx  <= idx + 1'b1;
            end
            if (finish) begin
                enable <= 1'b0;
                busy   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_led_frame_streamer.sv
// Directed bench for led_frame_streamer: an 8-pixel instance for streaming scenarios and a
// 1-pixel instance for exact single-transfer timing.
module tb_led_frame_streamer;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;

    logic        wr_en = 1'b0;
    logic [2:0]  wr_addr = '0;
    logic [23:0] wr_data = '0;
    logic        swap = 1'b0, start = 1'b0, ready = 1'b0;
    logic        busy, frame_done, enable;
    logic [23:0] data;

    logic        s_wr_en = 1'b0;
    logic [0:0]  s_wr_addr = '0;
    logic [23:0] s_wr_data = '0;
    logic        s_swap = 1'b0, s_start = 1'b0, s_ready = 1'b0;
    logic        s_busy, s_frame_done, s_enable;
    logic [23:0] s_data;

    int checks = 0;
    int failures = 0;

    led_frame_streamer #(.NUM_LEDS(8)) dut8 (
        .clock(clock), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .swap(swap), .start(start), .busy(busy), .frame_done(frame_done), .data(data),
        .enable(enable), .ready(ready)
    );

    led_frame_streamer #(.NUM_LEDS(1)) dut1 (
        .clock(clock), .reset_n(reset_n), .wr_en(s_wr_en), .wr_addr(s_wr_addr), .wr_data(s_wr_data),
        .swap(s_swap), .start(s_start), .busy(s_busy), .frame_done(s_frame_done), .data(s_data),
        .enable(s_enable), .ready(s_ready)
    );

    always #5 clock = ~clock;

    // Monitor on the falling edge: inputs change just after rising edges, so enable&&ready here
    // means a transfer at the next rising edge.
    logic [23:0] got[$];
    int          got_cyc[$];
    int          cyc = 0;
    int          busy_cycles = 0;
    int          done_cnt = 0;
    int          hold_err = 0;
    logic        held_valid = 1'b0;
    logic [23:0] held_data = '0;

    always @(posedge clock) cyc++;

    always @(negedge clock) begin
        if (enable && ready) begin
            got.push_back(data);
            got_cyc.push_back(cyc);
        end
        if (busy) busy_cycles++;
        if (frame_done) done_cnt++;
        if (!reset_n) begin
            held_valid = 1'b0;
        end else begin
            if (held_valid && (!enable || data !== held_data)) hold_err++;
            held_valid = enable && !ready;
            held_data  = data;
        end
    end

    logic [23:0] pa [8];
    logic [23:0] pb [8];

    function automatic logic [7:0] rev8(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = b[7-i];
        return r;
    endfunction

    // Expected wire word: {rev(B), rev(R), rev(G)}.
    function automatic logic [23:0] exp_word(input logic [23:0] p);
        return {rev8(p[7:0]), rev8(p[23:16]), rev8(p[15:8])};
    endfunction

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic write_px(input logic [2:0] a, input logic [23:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic pulse(input logic do_start, input logic do_swap);
        start = do_start; swap = do_swap;
        tick();
        start = 1'b0; swap = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget, input string name);
        int n = 0;
        while (done_cnt < target && n < budget) begin
            tick();
            n++;
        end
        if (done_cnt < target) begin
            checks++; failures++;
            $display("FAIL %s timeout: frames seen %0d, needed %0d", name, done_cnt, target);
        end
    endtask

    task automatic clear_mon();
        got.delete();
        got_cyc.delete();
        busy_cycles = 0;
        hold_err = 0;
    endtask

    task automatic test_reset();
        tick(3);
        checks++; if (enable !== 1'b0)     begin failures++; $display("FAIL reset_enable: got %b want 0", enable); end
        checks++; if (busy !== 1'b0)       begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL reset_frame_done: got %b want 0", frame_done); end
        checks++; if (data !== 24'h0)      begin failures++; $display("FAIL reset_data: got %h want 000000", data); end
        checks++; if (s_data !== 24'h0)    begin failures++; $display("FAIL reset_data_1led: got %h want 000000", s_data); end
        reset_n = 1'b1;
        tick(2);
    endtask

    task automatic test_single_led();
        s_wr_en = 1'b1; s_wr_addr = 1'b0; s_wr_data = 24'hFF0000;
        tick();
        s_wr_en = 1'b0; s_swap = 1'b1; s_start = 1'b1; s_ready = 1'b1;
        tick();
        s_swap = 1'b0; s_start = 1'b0;
        checks++; if (s_busy !== 1'b0) begin failures++; $display("FAIL single_busy_t: got %b want 0", s_busy); end
        tick();
        checks++; if (s_busy !== 1'b1)   begin failures++; $display("FAIL single_busy_launch: got %b want 1", s_busy); end
        checks++; if (s_enable !== 1'b0) begin failures++; $display("FAIL single_enable_launch: got %b want 0", s_enable); end
        tick();
        checks++; if (s_enable !== 1'b1)     begin failures++; $display("FAIL single_enable: got %b want 1", s_enable); end
        checks++; if (s_data !== 24'h00FF00) begin failures++; $display("FAIL single_data: got %h want 00ff00", s_data); end
        checks++; if (s_frame_done !== 1'b0) begin failures++; $display("FAIL single_done_early: got %b want 0", s_frame_done); end
        tick();
        checks++; if (s_enable !== 1'b0)     begin failures++; $display("FAIL single_enable_end: got %b want 0", s_enable); end
        checks++; if (s_frame_done !== 1'b1) begin failures++; $display("FAIL single_done: got %b want 1", s_frame_done); end
        checks++; if (s_busy !== 1'b0)       begin failures++; $display("FAIL single_busy_end: got %b want 0", s_busy); end
        tick();
        checks++; if (s_frame_done !== 1'b0) begin failures++; $display("FAIL single_done_pulse: got %b want 0", s_frame_done); end
        checks++; if (s_enable !== 1'b0)     begin failures++; $display("FAIL single_enable_after: got %b want 0", s_enable); end
    endtask

    task automatic test_back_to_back();
        int base;
        for (int k = 0; k < 8; k++) write_px(3'(k), pa[k]);
        ready = 1'b1;
        clear_mon();
        base = done_cnt;
        pulse(1'b1, 1'b1);
        wait_done(base + 1, 60, "b2b");
        tick(3);
        checks++; if (got.size() != 8) begin failures++; $display("FAIL b2b_count: got %0d want 8", got.size()); end
        checks++; if (busy_cycles != 9) begin failures++; $display("FAIL b2b_busy_cycles: got %0d want 9", busy_cycles); end
        if (got.size() == 8) begin
            checks++; if (got[0] !== 24'hC08040) begin failures++; $display("FAIL b2b_word0: got %h want c08040", got[0]); end
            checks++; if (got_cyc[7] - got_cyc[0] != 7) begin failures++; $display("FAIL b2b_gapless: span %0d want 7", got_cyc[7] - got_cyc[0]); end
            for (int k = 0; k < 8; k++) begin
                checks++;
                if (got[k] !== exp_word(pa[k])) begin failures++; $display("FAIL b2b_word%0d: got %h want %h", k, got[k], exp_word(pa[k])); end
            end
        end
    endtask

    task automatic test_ready_random();
        int base, n;
        clear_mon();
        base = done_cnt;
        ready = 1'b0;
        pulse(1'b1, 1'b0);
        n = 0;
        while (done_cnt < base + 1 && n < 300) begin
            ready = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        ready = 1'b1;
        checks++; if (done_cnt != base + 1) begin failures++; $display("FAIL rnd_frames: got %0d want %0d", done_cnt - base, 1); end
        checks++; if (hold_err != 0) begin failures++; $display("FAIL rnd_hold: got %0d unstable words want 0", hold_err); end
        checks++; if (got.size() != 8) begin failures++; $display("FAIL rnd_count: got %0d want 8", got.size()); end
        for (int k = 0; k < 8 && k < got.size(); k++) begin
            checks++;
            if (got[k] !== exp_word(pa[k])) begin failures++; $display("FAIL rnd_word%0d: got %h want %h", k, got[k], exp_word(pa[k])); end
        end
    endtask

    task automatic test_swap_mid_frame();
        int base;
        clear_mon();
        base = done_cnt;
        ready = 1'b0;
        pulse(1'b1, 1'b0);
        tick(2);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL swapmid_busy: got %b want 1", busy); end
        for (int k = 0; k < 8; k++) write_px(3'(k), pb[k]);
        pulse(1'b1, 1'b1);
        ready = 1'b1;
        wait_done(base + 2, 100, "swapmid");
        tick(10);
        checks++; if (done_cnt - base != 2) begin failures++; $display("FAIL swapmid_frames: got %0d want 2", done_cnt - base); end
        checks++; if (hold_err != 0) begin failures++; $display("FAIL swapmid_hold: got %0d want 0", hold_err); end
        checks++; if (got.size() != 16) begin failures++; $display("FAIL swapmid_count: got %0d want 16", got.size()); end
        for (int k = 0; k < 16 && k < got.size(); k++) begin
            logic [23:0] e;
            e = (k < 8) ? exp_word(pa[k]) : exp_word(pb[k-8]);
            checks++;
            if (got[k] !== e) begin failures++; $display("FAIL swapmid_word%0d: got %h want %h", k, got[k], e); end
        end
    endtask

    task automatic test_double_start();
        int base;
        clear_mon();
        base = done_cnt;
        ready = 1'b1;
        pulse(1'b1, 1'b0);
        tick(2);
        pulse(1'b1, 1'b0);
        tick();
        pulse(1'b1, 1'b0);
        wait_done(base + 2, 100, "dblstart");
        tick(20);
        checks++; if (done_cnt - base != 2) begin failures++; $display("FAIL dblstart_frames: got %0d want 2", done_cnt - base); end
        checks++; if (got.size() != 16) begin failures++; $display("FAIL dblstart_count: got %0d want 16", got.size()); end
        if (got.size() == 16) begin
            checks++; if (got[8] !== exp_word(pb[0])) begin failures++; $display("FAIL dblstart_word8: got %h want %h", got[8], exp_word(pb[0])); end
            checks++; if (got[15] !== exp_word(pb[7])) begin failures++; $display("FAIL dblstart_word15: got %h want %h", got[15], exp_word(pb[7])); end
        end
    endtask

    task automatic test_start_on_done();
        int base, n;
        clear_mon();
        base = done_cnt;
        ready = 1'b1;
        pulse(1'b1, 1'b0);
        n = 0;
        while (frame_done !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        checks++; if (frame_done !== 1'b1) begin failures++; $display("FAIL startdone_pulse: got %b want 1", frame_done); end
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(base + 2, 60, "startdone");
        tick(20);
        checks++; if (done_cnt - base != 2) begin failures++; $display("FAIL startdone_frames: got %0d want 2", done_cnt - base); end
        checks++; if (got.size() != 16) begin failures++; $display("FAIL startdone_count: got %0d want 16", got.size()); end
    endtask

    task automatic test_async_reset();
        int base;
        clear_mon();
        ready = 1'b1;
        pulse(1'b1, 1'b0);
        tick(5);
        checks++; if (got.size() != 3) begin failures++; $display("FAIL arst_sent: got %0d want 3", got.size()); end
        checks++; if (enable !== 1'b1) begin failures++; $display("FAIL arst_mid_enable: got %b want 1", enable); end
        reset_n = 1'b0;
        #1;
        checks++; if (enable !== 1'b0) begin failures++; $display("FAIL arst_enable: got %b want 0", enable); end
        checks++; if (busy !== 1'b0)   begin failures++; $display("FAIL arst_busy: got %b want 0", busy); end
        checks++; if (data !== 24'h0)  begin failures++; $display("FAIL arst_data: got %h want 000000", data); end
        tick(2);
        reset_n = 1'b1;
        tick(5);
        checks++; if (enable !== 1'b0) begin failures++; $display("FAIL arst_idle: got %b want 0", enable); end
        clear_mon();
        base = done_cnt;
        pulse(1'b1, 1'b0);
        wait_done(base + 1, 60, "arst_restart");
        tick(3);
        checks++; if (got.size() != 8) begin failures++; $display("FAIL arst_count: got %0d want 8", got.size()); end
        if (got.size() == 8) begin
            checks++; if (got[0] !== exp_word(pb[0])) begin failures++; $display("FAIL arst_word0: got %h want %h", got[0], exp_word(pb[0])); end
            checks++; if (got[7] !== exp_word(pb[7])) begin failures++; $display("FAIL arst_word7: got %h want %h", got[7], exp_word(pb[7])); end
        end
    endtask

    initial begin
        for (int k = 0; k < 8; k++) begin
            pa[k] = 24'h010203 + 24'(k) * 24'h111111;
            pb[k] = 24'hF0E0D0 - 24'(k) * 24'h101010;
        end
        test_reset();
        test_single_led();
        test_back_to_back();
        test_ready_random();
        test_swap_mid_frame();
        test_double_start();
        test_start_on_done();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
